// File: rtl/tdm_rx_pkg.sv
// Shared definitions for the TDM / I2S / left-justified serial audio receiver.
// Framing mode constants, receiver state encoding and a width helper.
package tdm_rx_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;
    localparam int MODE_TDM = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tdm_rx_if.sv
// Pad-side serial lines and the parallel frame output of the receiver.
// No backpressure: d is valid in the cycle ock is high, err marks a discarded frame.
interface tdm_rx_if #(
    parameter int ch = 2,
    parameter int b  = 16
);
    import tdm_rx_pkg::*;

    logic          sck;
    logic          ws;
    logic          sd;
    logic [ch*b-1:0] d;
    logic          ock;
    logic          err;
    logic          lock;
    rx_state_e     dbg_state;

    modport master (
        output sck, ws, sd,
        input  d, ock, err, lock, dbg_state
    );

    modport slave (
        input  sck, ws, sd,
        output d, ock, err, lock, dbg_state
    );

endinterface

// File: rtl/tdm_rx_sync_edge.sv
// Two-flop synchronizer for one asynchronous line, optionally followed by
// registered rise/fall detection (EDGE=0 gives the plain synchronizer).
module tdm_rx_sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], a_i};
    end

    assign s_o = sync_q[1];

    generate
        if (EDGE) begin : g_edge
            logic prev_q, rise_q, fall_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    prev_q <= s_o;
                    rise_q <= s_o & ~prev_q;
                    fall_q <= ~s_o & prev_q;
                end
            end

            assign rise_o = rise_q;
            assign fall_o = fall_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/tdm_rx.sv
// Multi-channel serial audio receiver (I2S, left-justified, TDM DSP-A).
// Oversamples sck/ws/sd, assembles ch slots and publishes whole frames.
module tdm_rx
    import tdm_rx_pkg::*;
#(
    parameter int b    = 16,
    parameter int sw   = 32,
    parameter int ch   = 2,
    parameter int mode = 0
) (
    input logic  clk,
    input logic  rst_n,
    tdm_rx_if.slave bus
);

    localparam int N   = ch * sw;
    localparam int PW  = clog2(N + 1);
    localparam int SLW = clog2(ch);
    localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

    logic sck_s, sck_rise, sck_fall, ws_s, sd_s;
    logic ws_r, ws_f, sd_r, sd_f, unused_sync;

    tdm_rx_sync_edge #(.EDGE(1'b1)) u_sck (
        .clk(clk), .rst_n(rst_n), .a_i(bus.sck),
        .s_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    tdm_rx_sync_edge #(.EDGE(1'b0)) u_ws (
        .clk(clk), .rst_n(rst_n), .a_i(bus.ws),
        .s_o(ws_s), .rise_o(ws_r), .fall_o(ws_f)
    );
    tdm_rx_sync_edge #(.EDGE(1'b0)) u_sd (
        .clk(clk), .rst_n(rst_n), .a_i(bus.sd),
        .s_o(sd_s), .rise_o(sd_r), .fall_o(sd_f)
    );

    assign unused_sync = ^{sck_s, sck_fall, ws_r, ws_f, sd_r, sd_f};

    rx_state_e       state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d, cap_pos;
    logic [b-1:0]    sh_q [ch];
    logic [b-1:0]    sh_d [ch];
    logic [b:0]      sh_ext;
    logic [ch*b-1:0] d_q, d_d;
    logic            ock_q, ock_d, err_q, err_d, ws_prev_q;
    logic            fs, do_cap, last_hit;
    logic [SLW-1:0]  cap_slot;
    logic [31:0]     cap_bit;

    // Frame start: falling ws for I2S/LJ, rising ws for TDM, judged on sck rise only.
    always_comb begin
        fs = 1'b0;
        if (sck_rise) begin
            if (mode == MODE_TDM) fs = ws_s & ~ws_prev_q;
            else                  fs = ws_prev_q & ~ws_s;
        end
    end

    // LJ has no data delay: the fs bit is pos 0 of the new frame.
    always_comb begin
        do_cap  = 1'b0;
        cap_pos = pos_q;
        if (fs && mode == MODE_LJ) begin
            do_cap  = 1'b1;
            cap_pos = '0;
        end else if (sck_rise && state_q == ST_RUN) begin
            do_cap = 1'b1;
        end
    end

    assign last_hit = do_cap && (cap_pos == POS_LAST);
    assign cap_slot = SLW'(32'(cap_pos) / sw);
    assign cap_bit  = 32'(cap_pos) % sw;

    always_comb begin
        state_d = state_q;
        if (fs)            state_d = ST_RUN;
        else if (last_hit) state_d = ST_HOLD;
    end

    always_comb begin
        ock_d = last_hit;
        err_d = fs && (state_q == ST_RUN) && !last_hit;
    end

    always_comb begin
        pos_d  = pos_q;
        sh_d   = sh_q;
        d_d    = d_q;
        sh_ext = '0;
        if (do_cap) begin
            if (cap_bit < 32'(b)) begin
                sh_ext           = {sh_q[cap_slot], sd_s};
                sh_d[cap_slot]   = sh_ext[b-1:0];
            end
            pos_d = cap_pos + 1'b1;
        end
        if (last_hit) begin
            for (int k = 0; k < ch; k++) d_d[k*b +: b] = sh_d[k];
        end
        if (fs && mode != MODE_LJ) pos_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q     <= '0;
            d_q       <= '0;
            ock_q     <= 1'b0;
            err_q     <= 1'b0;
            ws_prev_q <= 1'b0;
            for (int k = 0; k < ch; k++) sh_q[k] <= '0;
        end else begin
            pos_q <= pos_d;
            sh_q  <= sh_d;
            d_q   <= d_d;
            ock_q <= ock_d;
            err_q <= err_d;
            if (sck_rise) ws_prev_q <= ws_s;
        end
    end

    assign bus.d         = d_q;
    assign bus.ock       = ock_q;
    assign bus.err       = err_q;
    assign bus.lock      = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tdm_rx.sv
// Directed bench for tdm_rx: four instances (I2S b5, LJ b5, TDM 4x8, I2S b=sw=8)
// share the serial lines; each scenario task targets one instance.
`timescale 1ns/1ps
module tb_tdm_rx;
    import tdm_rx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sck, ws, sd;
    int   checks, errors;
    int   sel, ock_cnt, err_cnt, ock_lat;
    int   cur_mode, cur_sw, cur_b;
    logic [7:0] slot_val [4];
    logic sel_ock, sel_err;

    tdm_rx_if #(.ch(2), .b(5)) if0 ();
    tdm_rx_if #(.ch(2), .b(5)) if1 ();
    tdm_rx_if #(.ch(4), .b(8)) if2 ();
    tdm_rx_if #(.ch(2), .b(8)) if3 ();

    assign {if0.sck, if0.ws, if0.sd} = {sck, ws, sd};
    assign {if1.sck, if1.ws, if1.sd} = {sck, ws, sd};
    assign {if2.sck, if2.ws, if2.sd} = {sck, ws, sd};
    assign {if3.sck, if3.ws, if3.sd} = {sck, ws, sd};

    tdm_rx #(.b(5), .sw(8), .ch(2), .mode(0)) u_i2s  (.clk(clk), .rst_n(rst_n), .bus(if0));
    tdm_rx #(.b(5), .sw(8), .ch(2), .mode(1)) u_lj   (.clk(clk), .rst_n(rst_n), .bus(if1));
    tdm_rx #(.b(8), .sw(8), .ch(4), .mode(2)) u_tdm  (.clk(clk), .rst_n(rst_n), .bus(if2));
    tdm_rx #(.b(8), .sw(8), .ch(2), .mode(0)) u_i2s8 (.clk(clk), .rst_n(rst_n), .bus(if3));

    always_comb begin
        sel_ock = 1'b0;
        sel_err = 1'b0;
        case (sel)
            0: begin sel_ock = if0.ock; sel_err = if0.err; end
            1: begin sel_ock = if1.ock; sel_err = if1.err; end
            2: begin sel_ock = if2.ock; sel_err = if2.err; end
            3: begin sel_ock = if3.ock; sel_err = if3.err; end
            default: ;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        sck = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One sck period: 4 clk low with new ws/sd, then 4 clk high.
    // ock_lat = clk count after the sck rise at which ock was seen.
    task automatic send_bit(input logic w, input logic s);
        sck = 1'b0; ws = w; sd = s;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) sck = 1'b1;
            @(negedge clk);
            if (sel_ock) begin ock_cnt++; ock_lat = i - 4; end
            if (sel_err) err_cnt++;
        end
    endtask

    function automatic logic ws_at(input int p, input int n);
        case (cur_mode)
            0:       return (((p + 1) % n) >= cur_sw);
            1:       return (p >= cur_sw);
            default: return (p == n - 1);
        endcase
    endfunction

    task automatic send_frame(input int first, input int stop, input int n);
        logic [7:0] v;
        int bi;
        for (int p = first; p < stop; p++) begin
            v  = slot_val[p / cur_sw];
            bi = p % cur_sw;
            send_bit(ws_at(p, n), (bi < cur_b) ? v[cur_b-1-bi] : 1'b0);
        end
    endtask

    task automatic cfg(input int s, input int m, input int b);
        sel = s; cur_mode = m; cur_sw = 8; cur_b = b;
        ock_cnt = 0; err_cnt = 0; ock_lat = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (if0.d !== 10'd0) begin errors++; $display("FAIL reset_d: got %h want 0", if0.d); end
        checks++; if (if2.d !== 32'd0) begin errors++; $display("FAIL reset_d_tdm: got %h want 0", if2.d); end
        checks++; if (if0.ock !== 1'b0) begin errors++; $display("FAIL reset_ock: got %b want 0", if0.ock); end
        checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", if0.err); end
        checks++; if (if0.lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", if0.lock); end
        checks++; if (if0.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", if0.dbg_state, ST_IDLE); end
    endtask

    task automatic test_i2s();
        do_reset();
        cfg(0, 0, 5);
        slot_val[0] = 8'h16; slot_val[1] = 8'h0D;
        send_frame(0, 16, 16);
        checks++; if (if0.lock !== 1'b1) begin errors++; $display("FAIL i2s_lock: got %b want 1", if0.lock); end
        checks++; if (ock_cnt !== 0) begin errors++; $display("FAIL i2s_first_ock: got %0d want 0", ock_cnt); end
        repeat (3) send_frame(0, 16, 16);
        checks++; if (ock_cnt !== 3) begin errors++; $display("FAIL i2s_ock_cnt: got %0d want 3", ock_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL i2s_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (if0.d !== 10'b01101_10110) begin errors++; $display("FAIL i2s_d: got %b want 0110110110", if0.d); end
        checks++; if (ock_lat !== 4) begin errors++; $display("FAIL i2s_latency: got %0d want 4", ock_lat); end
    endtask

    task automatic test_lj();
        do_reset();
        cfg(1, 1, 5);
        slot_val[0] = 8'h16; slot_val[1] = 8'h0D;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (if1.lock !== 1'b0) begin errors++; $display("FAIL lj_prelock: got %b want 0", if1.lock); end
        repeat (3) send_frame(0, 16, 16);
        checks++; if (ock_cnt !== 3) begin errors++; $display("FAIL lj_ock_cnt: got %0d want 3", ock_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL lj_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (if1.d !== 10'b01101_10110) begin errors++; $display("FAIL lj_d: got %b want 0110110110", if1.d); end
        checks++; if (ock_lat !== 4) begin errors++; $display("FAIL lj_latency: got %0d want 4", ock_lat); end
    endtask

    task automatic test_tdm();
        do_reset();
        cfg(2, 2, 8);
        slot_val[0] = 8'hA1; slot_val[1] = 8'h5B; slot_val[2] = 8'hC3; slot_val[3] = 8'h7E;
        repeat (3) send_frame(0, 32, 32);
        checks++; if (ock_cnt !== 2) begin errors++; $display("FAIL tdm_ock_cnt: got %0d want 2", ock_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL tdm_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (if2.d !== 32'h7EC35BA1) begin errors++; $display("FAIL tdm_d: got %h want 7ec35ba1", if2.d); end
        checks++; if (ock_lat !== 4) begin errors++; $display("FAIL tdm_latency: got %0d want 4", ock_lat); end
    endtask

    // Continues from test_tdm: receiver is mid-run with d = 7EC35BA1.
    task automatic test_tdm_short();
        cfg(2, 2, 8);
        slot_val[0] = 8'hFF; slot_val[1] = 8'hEE; slot_val[2] = 8'hDD; slot_val[3] = 8'hCC;
        send_frame(0, 20, 20);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL short_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (ock_cnt !== 0) begin errors++; $display("FAIL short_ock_cnt: got %0d want 0", ock_cnt); end
        checks++; if (if2.d !== 32'h7EC35BA1) begin errors++; $display("FAIL short_d_kept: got %h want 7ec35ba1", if2.d); end
        slot_val[0] = 8'h12; slot_val[1] = 8'h34; slot_val[2] = 8'h56; slot_val[3] = 8'h78;
        send_frame(0, 32, 32);
        checks++; if (ock_cnt !== 1) begin errors++; $display("FAIL short_next_ock: got %0d want 1", ock_cnt); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL short_next_err: got %0d want 1", err_cnt); end
        checks++; if (if2.d !== 32'h78563412) begin errors++; $display("FAIL short_next_d: got %h want 78563412", if2.d); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg(0, 0, 5);
        slot_val[0] = 8'h16; slot_val[1] = 8'h0D;
        repeat (2) send_frame(0, 16, 16);
        checks++; if (ock_cnt !== 1) begin errors++; $display("FAIL rmid_pre_ock: got %0d want 1", ock_cnt); end
        send_frame(0, 10, 16);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if0.lock !== 1'b0) begin errors++; $display("FAIL rmid_lock_in_reset: got %b want 0", if0.lock); end
        checks++; if (if0.d !== 10'd0) begin errors++; $display("FAIL rmid_d_in_reset: got %h want 0", if0.d); end
        rst_n = 1'b1;
        ock_cnt = 0; err_cnt = 0;
        send_frame(10, 15, 16);
        checks++; if (if0.lock !== 1'b0) begin errors++; $display("FAIL rmid_lock_before_fs: got %b want 0", if0.lock); end
        send_frame(15, 16, 16);
        checks++; if (if0.lock !== 1'b1) begin errors++; $display("FAIL rmid_lock_after_fs: got %b want 1", if0.lock); end
        checks++; if (ock_cnt !== 0) begin errors++; $display("FAIL rmid_no_ock: got %0d want 0", ock_cnt); end
        send_frame(0, 16, 16);
        checks++; if (ock_cnt !== 1) begin errors++; $display("FAIL rmid_first_ock: got %0d want 1", ock_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rmid_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (if0.d !== 10'b01101_10110) begin errors++; $display("FAIL rmid_d: got %b want 0110110110", if0.d); end
    endtask

    task automatic test_full_slot();
        do_reset();
        cfg(3, 0, 8);
        slot_val[0] = 8'h3C; slot_val[1] = 8'hA5;
        repeat (3) send_frame(0, 16, 16);
        checks++; if (ock_cnt !== 2) begin errors++; $display("FAIL full_ock_cnt: got %0d want 2", ock_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL full_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (if3.d !== 16'hA53C) begin errors++; $display("FAIL full_d: got %h want a53c", if3.d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        sel = 0; cur_mode = 0; cur_sw = 8; cur_b = 5;
        ock_cnt = 0; err_cnt = 0; ock_lat = -1;
        for (int i = 0; i < 4; i++) slot_val[i] = 8'h00;
        test_reset();
        test_i2s();
        test_lj();
        test_tdm();
        test_tdm_short();
        test_reset_mid();
        test_full_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
